// File: rtl/pipe_stage_reg_if.sv
// Stage-boundary bus for pipe_stage_reg: stall/flush control, upstream word, downstream word, skid flags.
// PIPE_STAGE_PERF_CNT_EN adds the bubble_cnt signal.
interface pipe_stage_reg_if #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned STALL_W = 6
);
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic               up_valid;
  logic [DATA_W-1:0]  up_data;
  logic               dn_valid;
  logic [DATA_W-1:0]  dn_data;
  logic               skid_full;
  logic               skid_ovf;
`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [31:0]        bubble_cnt;

  modport master (
    output stall, flush, up_valid, up_data,
    input  dn_valid, dn_data, skid_full, skid_ovf, bubble_cnt
  );
  modport slave (
    input  stall, flush, up_valid, up_data,
    output dn_valid, dn_data, skid_full, skid_ovf, bubble_cnt
  );
`else
  modport master (
    output stall, flush, up_valid, up_data,
    input  dn_valid, dn_data, skid_full, skid_ovf
  );
  modport slave (
    input  stall, flush, up_valid, up_data,
    output dn_valid, dn_data, skid_full, skid_ovf
  );
`endif
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with flush, global stall vector and a one-entry skid slot.
// Optional bubble counter enabled by defining PIPE_STAGE_PERF_CNT_EN.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W     = 64,
  parameter int unsigned       STAGE      = 1,
  parameter int unsigned       STALL_W    = 6,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  pipe_stage_reg_if.slave   bus
);

  localparam int unsigned HU_IDX = STAGE;
  localparam int unsigned HD_IDX = STAGE + 1;

  if (HD_IDX >= STALL_W) begin : g_bad_stage
    $error("pipe_stage_reg: STAGE+1 must be below STALL_W");
  end

  logic              hu, hd;
  logic              unused_stall;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q,  m_data_d;
  logic              s_valid_q, s_valid_d;
  logic [DATA_W-1:0] s_data_q,  s_data_d;
  logic              ovf_q,     ovf_d;

  assign hu           = bus.stall[HU_IDX];
  assign hd           = bus.stall[HD_IDX];
  // Only two bits of the global vector matter to this boundary.
  assign unused_stall = ^bus.stall;

  // Next-state selection in flush > stall priority order.
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    ovf_d     = ovf_q;
    if (bus.flush) begin
      m_valid_d = 1'b0;
      m_data_d  = BUBBLE_VAL;
      s_valid_d = 1'b0;
      s_data_d  = BUBBLE_VAL;
    end else if (hd) begin
      if (!hu && bus.up_valid) begin
        if (!s_valid_q) begin
          s_valid_d = 1'b1;
          s_data_d  = bus.up_data;
        end else begin
          ovf_d = 1'b1;
        end
      end
    end else if (hu) begin
      m_valid_d = s_valid_q;
      m_data_d  = s_valid_q ? s_data_q : BUBBLE_VAL;
      s_valid_d = 1'b0;
      s_data_d  = BUBBLE_VAL;
    end else if (s_valid_q) begin
      m_valid_d = 1'b1;
      m_data_d  = s_data_q;
      s_valid_d = bus.up_valid;
      s_data_d  = bus.up_valid ? bus.up_data : BUBBLE_VAL;
    end else begin
      m_valid_d = bus.up_valid;
      m_data_d  = bus.up_valid ? bus.up_data : BUBBLE_VAL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_data_q  <= BUBBLE_VAL;
      s_valid_q <= 1'b0;
      s_data_q  <= BUBBLE_VAL;
      ovf_q     <= 1'b0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.dn_valid  = m_valid_q;
  assign bus.dn_data   = m_data_q;
  assign bus.skid_full = s_valid_q;
  assign bus.skid_ovf  = ovf_q;

`ifdef PIPE_STAGE_PERF_CNT_EN
  localparam int unsigned CNT_W = 32;

  logic             bubble_c;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A bubble enters M on hu-only with empty skid, or on no-stall with nothing to move.
  always_comb begin
    bubble_c = !bus.flush && !hd && !s_valid_q && (hu || !bus.up_valid);
    cnt_d    = cnt_q;
    if (bubble_c && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.bubble_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed table-driven bench for pipe_stage_reg (STAGE=1: hu=stall[1], hd=stall[2]).
// Bubble counter checks run only when PIPE_STAGE_PERF_CNT_EN is defined.
module tb_pipe_stage_reg;

  localparam int unsigned DW = 16;
  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_HU   = 6'b000010;
  localparam logic [5:0] S_HD   = 6'b000100;
  localparam logic [5:0] S_BOTH = 6'b000110;
  localparam logic [5:0] S_OTHR = 6'b111001;

  typedef struct {
    logic [5:0]    stall;
    logic          flush;
    logic          up_valid;
    logic [DW-1:0] up_data;
    logic          e_valid;
    logic [DW-1:0] e_data;
    logic          e_full;
    logic          e_ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(DW), .STALL_W(6)) bus ();

  pipe_stage_reg #(
    .DATA_W(DW), .STAGE(1), .STALL_W(6), .BUBBLE_VAL('0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic vec_t v(logic [5:0] st, logic fl, logic uv, logic [DW-1:0] ud,
                             logic ev, logic [DW-1:0] ed, logic ef, logic eo);
    vec_t r;
    r.stall = st; r.flush = fl; r.up_valid = uv; r.up_data = ud;
    r.e_valid = ev; r.e_data = ed; r.e_full = ef; r.e_ovf = eo;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] st, input logic fl, input logic uv, input logic [DW-1:0] ud);
    bus.stall    = st;
    bus.flush    = fl;
    bus.up_valid = uv;
    bus.up_data  = ud;
  endtask

  task automatic check_outs(input string tag, input logic ev, input logic [DW-1:0] ed,
                            input logic ef, input logic eo);
    check({tag, " dn_valid"},  32'(bus.dn_valid),  32'(ev));
    check({tag, " dn_data"},   32'(bus.dn_data),   32'(ed));
    check({tag, " skid_full"}, 32'(bus.skid_full), 32'(ef));
    check({tag, " skid_ovf"},  32'(bus.skid_ovf),  32'(eo));
  endtask

  initial begin
    // Streaming, bubble insertion
    vq.push_back(v(S_NONE, 0, 1, 16'h0001, 1, 16'h0001, 0, 0));
    vq.push_back(v(S_NONE, 0, 1, 16'h0002, 1, 16'h0002, 0, 0));
    vq.push_back(v(S_HU,   0, 1, 16'h000A, 0, 16'h0000, 0, 0));
    vq.push_back(v(S_NONE, 0, 1, 16'h000A, 1, 16'h000A, 0, 0));
    // Skid path: hd for 3 cycles, word taken at the first edge
    vq.push_back(v(S_NONE, 0, 1, 16'h0009, 1, 16'h0009, 0, 0));
    vq.push_back(v(S_HD,   0, 1, 16'h000B, 1, 16'h0009, 1, 0));
    vq.push_back(v(S_HD,   0, 0, 16'h0000, 1, 16'h0009, 1, 0));
    vq.push_back(v(S_HD,   0, 0, 16'h0000, 1, 16'h0009, 1, 0));
    vq.push_back(v(S_NONE, 0, 1, 16'h000D, 1, 16'h000B, 1, 0));
    vq.push_back(v(S_NONE, 0, 0, 16'h0000, 1, 16'h000D, 0, 0));
    vq.push_back(v(S_NONE, 0, 0, 16'h0000, 0, 16'h0000, 0, 0));
    // Overflow: 0xC dropped, 0xB still delivered
    vq.push_back(v(S_NONE, 0, 1, 16'h0009, 1, 16'h0009, 0, 0));
    vq.push_back(v(S_HD,   0, 1, 16'h000B, 1, 16'h0009, 1, 0));
    vq.push_back(v(S_HD,   0, 1, 16'h000C, 1, 16'h0009, 1, 1));
    vq.push_back(v(S_HD,   0, 0, 16'h0000, 1, 16'h0009, 1, 1));
    vq.push_back(v(S_NONE, 0, 0, 16'h0000, 1, 16'h000B, 0, 1));
    vq.push_back(v(S_NONE, 0, 0, 16'h0000, 0, 16'h0000, 0, 1));
    // Both stalled holds M and S; hu-only drains S into M
    vq.push_back(v(S_NONE, 0, 1, 16'h0021, 1, 16'h0021, 0, 1));
    vq.push_back(v(S_BOTH, 0, 1, 16'h0022, 1, 16'h0021, 0, 1));
    vq.push_back(v(S_HD,   0, 1, 16'h0022, 1, 16'h0021, 1, 1));
    vq.push_back(v(S_BOTH, 0, 1, 16'h0023, 1, 16'h0021, 1, 1));
    vq.push_back(v(S_HU,   0, 1, 16'h0023, 1, 16'h0022, 0, 1));
    vq.push_back(v(S_NONE, 0, 1, 16'h0023, 1, 16'h0023, 0, 1));
    // Flush beats stall; ovf sticky
    vq.push_back(v(S_HD,   0, 1, 16'h0024, 1, 16'h0023, 1, 1));
    vq.push_back(v(S_HD,   1, 1, 16'h0025, 0, 16'h0000, 0, 1));
    vq.push_back(v(S_NONE, 0, 1, 16'h0026, 1, 16'h0026, 0, 1));
    vq.push_back(v(S_NONE, 1, 1, 16'h0027, 0, 16'h0000, 0, 1));
    // Unrelated stall bits are ignored
    vq.push_back(v(S_OTHR, 0, 1, 16'h0028, 1, 16'h0028, 0, 1));
    vq.push_back(v(S_OTHR, 0, 0, 16'h0000, 0, 16'h0000, 0, 1));

    drive(S_NONE, 0, 0, '0);
    #1;
    check_outs("reset", 0, 16'h0000, 0, 0);

    @(negedge clk);
    rst = 1'b0;
    foreach (vq[i]) begin
      drive(vq[i].stall, vq[i].flush, vq[i].up_valid, vq[i].up_data);
      @(posedge clk);
      #1;
      check_outs($sformatf("v%0d", i), vq[i].e_valid, vq[i].e_data, vq[i].e_full, vq[i].e_ovf);
      @(negedge clk);
    end

    // Asynchronous reset mid-stream, with skid full and ovf set
    drive(S_NONE, 0, 1, 16'h0031);
    @(posedge clk);
    #1;
    check_outs("pre_rst", 1, 16'h0031, 0, 1);
    drive(S_HD, 0, 1, 16'h0032);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_outs("async_rst", 0, 16'h0000, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(S_NONE, 0, 1, 16'h0033);
    @(posedge clk);
    #1;
    check_outs("post_rst", 1, 16'h0033, 0, 0);
    @(negedge clk);

`ifdef PIPE_STAGE_PERF_CNT_EN
    rst = 1'b1;
    drive(S_HU, 0, 0, '0);
    #1;
    check("cnt_reset", bus.bubble_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("cnt_5", bus.bubble_cnt, 32'd5);
    @(negedge clk);
    drive(S_NONE, 1, 0, '0);
    @(posedge clk);
    #1;
    check("cnt_flush", bus.bubble_cnt, 32'd5);
    @(negedge clk);
    drive(S_NONE, 0, 1, 16'h0040);
    @(posedge clk);
    #1;
    check("cnt_valid", bus.bubble_cnt, 32'd5);
    @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
